dot_int_acc_ctrl: RTL and testbench
===================================

Name: dot_int_acc_ctrl

Overview:
- Sequencer around the k-wide `dot_int` datapath.
- Computes a dot product of length `num_blocks*k` by streaming k-element operand beats through one `dot_int` instance and accumulating the partial sums.
- Sits between an operand-fetch stage (valid/ready input) and a result consumer (valid/ready output).
- Used wherever vector length exceeds k, e.g. MX block-level accumulation.

Parameters:
- bit_width, 8, element width of signed operands
- k, 32, elements per beat (`dot_int` width)
- max_blocks, 16, max beats per dot product
- blk_width, $clog2(max_blocks)+1, width of block-count input
- dp_width, 2*bit_width+$clog2(k), `dot_int` output width
- acc_width, dp_width+$clog2(max_blocks), accumulator/result width

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  synchronous, active-high reset
- i_num_blocks  input  blk_width  beats in current dot product; sampled on first beat only
- i_vec_a  input  signed [bit_width-1:0] x k  operand A beat
- i_vec_b  input  signed [bit_width-1:0] x k  operand B beat
- i_valid  input  1  operand beat valid
- o_ready  output  1  block accepts operand beat
- o_dp  output  signed acc_width  accumulated dot product
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result
- o_busy  output  1  dot product in progress (state != IDLE)

Behaviour:
- Clock is i_clk. Reset is synchronous, active-high, on i_rst.
- Reset values: state=IDLE, o_valid=0, o_dp=0, o_busy=0, beat counter=0, accumulator=0. o_ready=1 in the cycle after reset.
- Beat accept: i_valid && o_ready at the rising edge. Result handshake: o_valid && i_ready.
- o_ready = (state==IDLE || state==ACCUM). It is low throughout OUTPUT, so results never overlap; this costs one bubble per result.
- Datapath: `dot_int` is combinational on i_vec_a/i_vec_b. Its dp_width result is sign-extended to acc_width before the add.
- Block count, latched on the accepted beat in IDLE:
  - n = i_num_blocks
  - 0 is treated as 1
  - values > max_blocks are clamped to max_blocks
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE:
  - On accept: acc <= dp; remaining <= n-1.
  - If n==1 -> OUTPUT, else -> ACCUM.
  - With no accept, stay in IDLE.
- ACCUM:
  - On accept: acc <= acc + dp; remaining <= remaining-1.
  - If remaining==1 before the decrement -> OUTPUT.
  - With no accept (i_valid low), hold all state indefinitely.
- OUTPUT:
  - o_valid=1 and o_dp=acc.
  - o_dp is held stable until the handshake.
  - On i_ready: o_valid deasserts next cycle and state -> IDLE.
- Latency: o_valid rises the cycle after the last beat is accepted. Minimum period per result is n+1 cycles.
- i_num_blocks is ignored outside the IDLE accept cycle. Changes mid-product have no effect.
- Arithmetic: two's complement throughout. acc_width guarantees no overflow for max_blocks beats of full-scale operands, e.g. (-2^(bit_width-1))^2 * k * max_blocks.
- i_ready high while o_valid is low: no effect.
- Reset mid-operation: any partial sum is discarded and the block returns to the reset state. A pending result is dropped without a handshake.

Decomposition:
- Package `dot_ctrl_pkg`:
  - state typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT}
  - function clamp_blocks(n, max) returning n' per the rules above
- Sub-module: one instance of existing `dot_int` (bit_width, k). No new sub-module.
- The FSM and accumulator live in `dot_int_acc_ctrl`.

Test Plan:
- Single block: n=1, a=all 1, b=all 2 (k=32) -> o_valid one cycle after accept, o_dp=64; IDLE after i_ready.
- Multi-block with stalls: n=4, beats of a=all 3, b=all -1, with i_valid low for 2 cycles between beats 2 and 3 -> o_dp=-384; o_ready high during the stalls; o_valid only after beat 4.
- Extremes / no overflow: n=16, a=b=all -128 -> o_dp=+8388608 (16384*32*16); no wrap with acc_width=25.
- Count edge cases: n=0 behaves as n=1. n=31 (>16) clamps to 16; the 17th beat starts a new product. Changing i_num_blocks mid-product does not alter beat count.
- Backpressure: i_ready held low for 5 cycles in OUTPUT -> o_dp stable, o_valid held, o_ready=0 (offered beat not accepted); release -> IDLE next cycle.
- Reset mid-operation: i_rst asserted after 2 of 4 beats -> next cycle o_valid=0, o_busy=0, o_ready=1; new n=1 product of a=b=all 1 yields o_dp=32 (no residue).

Source files
------------

// File: rtl/dot_ctrl_pkg.sv
// Shared types and helpers for the dot_int accumulation sequencer.
package dot_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  // A zero count still produces one beat; oversize counts saturate at max_n.
  function automatic int unsigned clamp_blocks(input int unsigned n, input int unsigned max_n);
    if (n == 0) return 1;
    else if (n > max_n) return max_n;
    else return n;
  endfunction

endpackage

// File: rtl/dot_int.sv
// Combinational k-wide signed integer dot product.
module dot_int #(
  parameter int bit_width = 8,
  parameter int k         = 32,
  parameter int dp_width  = 2*bit_width+$clog2(k)
) (
  input  logic signed [bit_width-1:0] i_vec_a [k],
  input  logic signed [bit_width-1:0] i_vec_b [k],
  output logic signed [dp_width-1:0]  o_dp
);

  logic signed [dp_width-1:0] sum;

  // Operands are widened before the multiply so the product is never truncated.
  always_comb begin
    sum = '0;
    for (int i = 0; i < k; i++) begin
      sum = sum + (dp_width'(i_vec_a[i]) * dp_width'(i_vec_b[i]));
    end
  end

  assign o_dp = sum;

endmodule

// File: rtl/dot_int_acc_ctrl.sv
// Streams num_blocks operand beats through dot_int and accumulates them into one result.
// One result in flight at a time; input is stalled while the result waits for the consumer.
module dot_int_acc_ctrl
  import dot_ctrl_pkg::*;
#(
  parameter int bit_width  = 8,
  parameter int k          = 32,
  parameter int max_blocks = 16,
  parameter int blk_width  = $clog2(max_blocks)+1,
  parameter int dp_width   = 2*bit_width+$clog2(k),
  parameter int acc_width  = dp_width+$clog2(max_blocks)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [blk_width-1:0]        i_num_blocks,
  input  logic signed [bit_width-1:0] i_vec_a [k],
  input  logic signed [bit_width-1:0] i_vec_b [k],
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic signed [acc_width-1:0] o_dp,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_busy
);

  state_t                      state;
  state_t                      next_state;
  logic [blk_width-1:0]        remaining;
  logic [blk_width-1:0]        n_clamped;
  logic signed [acc_width-1:0] acc;
  logic signed [dp_width-1:0]  dp;
  logic signed [acc_width-1:0] dp_ext;
  logic                        accept;

  dot_int #(
    .bit_width (bit_width),
    .k         (k),
    .dp_width  (dp_width)
  ) u_dot_int (
    .i_vec_a (i_vec_a),
    .i_vec_b (i_vec_b),
    .o_dp    (dp)
  );

  assign dp_ext    = acc_width'(dp);
  assign n_clamped = blk_width'(clamp_blocks(32'(i_num_blocks), 32'(max_blocks)));
  assign accept    = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = (n_clamped == blk_width'(1)) ? OUTPUT : ACCUM;
      ACCUM:   if (accept && remaining == blk_width'(1)) next_state = OUTPUT;
      OUTPUT:  if (i_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE) || (state == ACCUM);
    o_valid = (state == OUTPUT);
    o_busy  = (state != IDLE);
  end

  // The first beat overwrites the accumulator, so no explicit clear is needed between products.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc       <= '0;
      remaining <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        acc       <= dp_ext;
        remaining <= n_clamped - blk_width'(1);
      end else begin
        acc       <= acc + dp_ext;
        remaining <= remaining - blk_width'(1);
      end
    end
  end

  assign o_dp = acc;

endmodule

// File: tb/tb_dot_int_acc_ctrl.sv
// Scoreboard bench: directed and random products against a plain-arithmetic dot product model.
module tb_dot_int_acc_ctrl;

  localparam int BW = 8;
  localparam int K  = 32;
  localparam int MB = 16;
  localparam int BLKW = $clog2(MB)+1;
  localparam int ACCW = 2*BW+$clog2(K)+$clog2(MB);

  logic                   clk = 0;
  logic                   i_rst = 1;
  logic [BLKW-1:0]        i_num_blocks = '0;
  logic signed [BW-1:0]   va [K];
  logic signed [BW-1:0]   vb [K];
  logic                   i_valid = 0;
  logic                   o_ready;
  logic signed [ACCW-1:0] o_dp;
  logic                   o_valid;
  logic                   i_ready = 0;
  logic                   o_busy;

  int     n_checks = 0;
  int     n_fail = 0;
  int     rdy_mode = 0;
  longint exp_q [$];

  dot_int_acc_ctrl #(.bit_width(BW), .k(K), .max_blocks(MB)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_num_blocks (i_num_blocks),
    .i_vec_a      (va),
    .i_vec_b      (vb),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_dp         (o_dp),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Consumer readiness: 0 = always ready, 1 = random, 2 = held off.
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ($urandom_range(0, 3) != 0);
      default: i_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every result handshake.
  initial begin
    bit     post_chk = 0;
    bit     hold_vld = 0;
    longint held = 0;
    longint e;
    forever begin
      @(negedge clk);
      if (i_rst) begin
        post_chk = 0;
        hold_vld = 0;
      end else begin
        if (post_chk) begin
          check("post_hs_valid", o_valid, 0);
          check("post_hs_busy", o_busy, 0);
          check("post_hs_ready", o_ready, 1);
          post_chk = 0;
        end
        if (o_valid) begin
          check("out_ready_low", o_ready, 0);
          if (hold_vld) check("dp_stable", longint'(o_dp), held);
          if (exp_q.size() == 0) begin
            check("unexpected_valid", o_valid, 0);
            hold_vld = 0;
          end else if (i_ready) begin
            e = exp_q.pop_front();
            check("result", longint'(o_dp), e);
            post_chk = 1;
            hold_vld = 0;
          end else begin
            hold_vld = 1;
            held = longint'(o_dp);
          end
        end else begin
          hold_vld = 0;
        end
      end
    end
  end

  task automatic drive_beat();
    bit done = 0;
    i_valid = 1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      done = o_ready;
      @(posedge clk);
      #1;
    end
    i_valid = 0;
    if (!done) check("beat_accept_timeout", 0, 1);
  endtask

  // nsend==0 sends the full (clamped) product; push==0 sends without expecting a result.
  task automatic run_product(input int n_req, input int av, input int bv, input bit rnd,
                             input int nsend, input int stall_at, input int stall_len,
                             input bit push);
    int     n_eff;
    int     cnt;
    longint exp_v = 0;
    n_eff = (n_req == 0) ? 1 : (n_req > MB) ? MB : n_req;
    cnt = (nsend == 0) ? n_eff : nsend;
    for (int bt = 0; bt < cnt; bt++) begin
      if (bt == stall_at && bt > 0) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check("stall_ready", o_ready, 1);
          check("stall_no_valid", o_valid, 0);
          @(posedge clk);
          #1;
        end
      end
      for (int i = 0; i < K; i++) begin
        va[i] = rnd ? BW'($urandom) : BW'(av);
        vb[i] = rnd ? BW'($urandom) : BW'(bv);
        exp_v += longint'(va[i]) * longint'(vb[i]);
      end
      i_num_blocks = (bt == 0) ? BLKW'(n_req) : BLKW'($urandom);
      drive_beat();
    end
    if (push) begin
      exp_q.push_back(exp_v);
      @(negedge clk);
      check("latency_valid", o_valid, 1);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < K; i++) begin
      va[i] = '0;
      vb[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    i_rst = 0;
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_dp", longint'(o_dp), 0);
    check("rst_busy", o_busy, 0);
    check("rst_ready", o_ready, 1);
    @(posedge clk);
    #1;

    run_product(1, 1, 2, 0, 0, -1, 0, 1);      // 64
    run_product(4, 3, -1, 0, 0, 2, 2, 1);      // -384 with stall before beat 3
    run_product(16, -128, -128, 0, 0, -1, 0, 1); // +8388608
    run_product(0, 2, 2, 0, 0, -1, 0, 1);      // n=0 acts as 1: 128
    run_product(31, 1, 1, 0, 0, -1, 0, 1);     // clamps to 16 beats: 512
    run_product(1, 5, 1, 0, 0, -1, 0, 1);      // the 17th beat starts a new product

    // Backpressure: result held for 5 cycles while a beat is offered.
    rdy_mode = 2;
    @(posedge clk);
    #2;
    run_product(1, 1, 2, 0, 0, -1, 0, 1);
    for (int c = 0; c < 5; c++) begin
      i_valid = 1;
      @(negedge clk);
      check("bp_valid", o_valid, 1);
      check("bp_ready", o_ready, 0);
      @(posedge clk);
      #1;
    end
    i_valid = 0;
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset after 2 of 4 beats discards the partial sum.
    run_product(4, 7, 7, 0, 2, -1, 0, 0);
    i_rst = 1;
    @(posedge clk);
    #1;
    i_rst = 0;
    @(negedge clk);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_ready", o_ready, 1);
    @(posedge clk);
    #1;
    run_product(1, 1, 1, 0, 0, -1, 0, 1);      // 32

    rdy_mode = 1;
    for (int p = 0; p < 25; p++) begin
      run_product($urandom_range(0, 20), 0, 0, 1, 0, $urandom_range(0, 6),
                  $urandom_range(0, 3), 1);
    end
    rdy_mode = 0;

    for (int c = 0; c < 1000 && exp_q.size() != 0; c++) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
